home_automation_ctrl: RTL and testbench

//  Multi-zone successor to the single-zone home controller. Per zone, it drives

---
 rtl/home_automation_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_home_automation_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/home_automation_ctrl.sv
// Multi-zone home controller: per-zone heater/cooler hysteresis, 3-level lighting,
// and latched fire/door alarms with a minimum hold time and operator acknowledge.
module home_automation_ctrl #(
   parameter int unsigned DW       = 8,
   parameter int unsigned NZ       = 4,
   parameter int unsigned T_LOW    = 68,
   parameter int unsigned T_SET    = 70,
   parameter int unsigned T_HIGH   = 72,
   parameter int unsigned L_DARK   = 15,
   parameter int unsigned L_BRIGHT = 120,
   parameter int unsigned ALRM_CYC = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [NZ*DW-1:0] temp_sen_i,
   input  logic [DW-1:0]    lum_sen_i,
   input  logic             d_sen_i,
   input  logic             f_sen_i,
   input  logic             alrm_ack_i,
   output logic             b_alrm_o,
   output logic             f_alrm_o,
   output logic [NZ-1:0]    heater_o,
   output logic [NZ-1:0]    cooler_o,
   output logic             l_high_o,
   output logic             l_low_o,
   output logic [1:0]       state_o
);

   localparam int unsigned CW = $clog2(ALRM_CYC + 1);
   localparam logic [CW-1:0] CntLoad = CW'(ALRM_CYC - 1);
   localparam logic [DW-1:0] TLow    = DW'(T_LOW);
   localparam logic [DW-1:0] TSet    = DW'(T_SET);
   localparam logic [DW-1:0] THigh   = DW'(T_HIGH);
   localparam logic [DW-1:0] LDark   = DW'(L_DARK);
   localparam logic [DW-1:0] LBright = DW'(L_BRIGHT);

   typedef enum logic [1:0] {
      StRun  = 2'd0,
      StDoor = 2'd1,
      StFire = 2'd2
   } state_e;

   // Registered sensor inputs
   logic [NZ*DW-1:0] temp_q;
   logic [DW-1:0]    lum_q;
   logic             d_q, f_q, ack_q;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_dec;
   logic             pend_q, pend_d;
   logic             b_alrm_q, b_alrm_d;
   logic             f_alrm_q, f_alrm_d;
   logic [NZ-1:0]    heater_q, heater_d;
   logic [NZ-1:0]    cooler_q, cooler_d;
   logic             l_high_q, l_high_d;
   logic             l_low_q, l_low_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      cnt_dec = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      case (state_q)
         StRun: begin
            if (f_q) begin
               state_d = StFire;
               cnt_d   = CntLoad;
               pend_d  = d_q;
            end else if (d_q) begin
               state_d = StDoor;
               cnt_d   = CntLoad;
            end
         end
         StDoor: begin
            if (f_q) begin
               state_d = StFire;
               cnt_d   = CntLoad;
               pend_d  = 1'b1;
            end else if (cnt_q == '0 && ack_q && !d_q) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_dec;
            end
         end
         StFire: begin
            pend_d = pend_q | d_q;
            if (cnt_q == '0 && ack_q && !f_q) begin
               // A door event seen during the fire is serviced next.
               if (pend_d) begin
                  state_d = StDoor;
                  cnt_d   = CntLoad;
                  pend_d  = 1'b0;
               end else begin
                  state_d = StRun;
               end
            end else begin
               cnt_d = cnt_dec;
            end
         end
         default: begin
            state_d = StRun;
            cnt_d   = '0;
            pend_d  = 1'b0;
         end
      endcase
   end

   // Outputs are computed from the next state so they change on the same edge.
   always_comb begin
      b_alrm_d = (state_d == StDoor);
      f_alrm_d = (state_d == StFire);
      heater_d = '0;
      cooler_d = '0;
      l_high_d = 1'b0;
      l_low_d  = 1'b0;
      if (state_d == StFire) begin
         l_high_d = 1'b1;
      end else begin
         // Held state is zero during FIRE, so zones restart from 0 on exit.
         for (int unsigned z = 0; z < NZ; z++) begin
            heater_d[z] = heater_q[z];
            cooler_d[z] = cooler_q[z];
            if (temp_q[z*DW +: DW] < TLow) begin
               heater_d[z] = 1'b1;
            end else if (temp_q[z*DW +: DW] >= TSet) begin
               heater_d[z] = 1'b0;
            end
            if (temp_q[z*DW +: DW] > THigh) begin
               cooler_d[z] = 1'b1;
            end else if (temp_q[z*DW +: DW] <= TSet) begin
               cooler_d[z] = 1'b0;
            end
         end
         if (lum_q < LDark) begin
            l_high_d = 1'b1;
         end else if (lum_q < LBright) begin
            l_low_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         temp_q   <= '0;
         lum_q    <= '0;
         d_q      <= 1'b0;
         f_q      <= 1'b0;
         ack_q    <= 1'b0;
         state_q  <= StRun;
         cnt_q    <= '0;
         pend_q   <= 1'b0;
         b_alrm_q <= 1'b0;
         f_alrm_q <= 1'b0;
         heater_q <= '0;
         cooler_q <= '0;
         l_high_q <= 1'b0;
         l_low_q  <= 1'b0;
      end else begin
         temp_q   <= temp_sen_i;
         lum_q    <= lum_sen_i;
         d_q      <= d_sen_i;
         f_q      <= f_sen_i;
         ack_q    <= alrm_ack_i;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         b_alrm_q <= b_alrm_d;
         f_alrm_q <= f_alrm_d;
         heater_q <= heater_d;
         cooler_q <= cooler_d;
         l_high_q <= l_high_d;
         l_low_q  <= l_low_d;
      end
   end

   assign b_alrm_o = b_alrm_q;
   assign f_alrm_o = f_alrm_q;
   assign heater_o = heater_q;
   assign cooler_o = cooler_q;
   assign l_high_o = l_high_q;
   assign l_low_o  = l_low_q;
   assign state_o  = state_q;

   a_no_heat_cool: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (heater_q & cooler_q) == '0);
   a_no_both_lights: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(l_high_q && l_low_q));

endmodule

// File: tb/tb_home_automation_ctrl.sv
// Directed self-checking bench for home_automation_ctrl: table-driven climate and
// lighting vectors plus hand-written alarm sequences.
module tb_home_automation_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] temp_sen;
   logic [7:0]  lum_sen;
   logic        d_sen, f_sen, alrm_ack;
   logic        b_alrm, f_alrm, l_high, l_low;
   logic [3:0]  heater, cooler;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   home_automation_ctrl dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .temp_sen_i (temp_sen),
      .lum_sen_i  (lum_sen),
      .d_sen_i    (d_sen),
      .f_sen_i    (f_sen),
      .alrm_ack_i (alrm_ack),
      .b_alrm_o   (b_alrm),
      .f_alrm_o   (f_alrm),
      .heater_o   (heater),
      .cooler_o   (cooler),
      .l_high_o   (l_high),
      .l_low_o    (l_low),
      .state_o    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] t0;
      logic [7:0] lum;
      logic [3:0] heat;
      logic [3:0] cool;
      logic       lh;
      logic       ll;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_state(input logic [1:0] exp, input int bound, input string name);
      int n;
      n = 0;
      while (state !== exp && n < bound) begin
         step();
         n++;
      end
      check(name, {30'd0, state}, {30'd0, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int len;

      vecs[0] = '{t0: 8'd60, lum: 8'd0,   heat: 4'b0001, cool: 4'b0000, lh: 1'b1, ll: 1'b0};
      vecs[1] = '{t0: 8'd69, lum: 8'd14,  heat: 4'b0001, cool: 4'b0000, lh: 1'b1, ll: 1'b0};
      vecs[2] = '{t0: 8'd71, lum: 8'd15,  heat: 4'b0000, cool: 4'b0000, lh: 1'b0, ll: 1'b1};
      vecs[3] = '{t0: 8'd75, lum: 8'd119, heat: 4'b0000, cool: 4'b0001, lh: 1'b0, ll: 1'b1};
      vecs[4] = '{t0: 8'd71, lum: 8'd120, heat: 4'b0000, cool: 4'b0001, lh: 1'b0, ll: 1'b0};
      vecs[5] = '{t0: 8'd70, lum: 8'd255, heat: 4'b0000, cool: 4'b0000, lh: 1'b0, ll: 1'b0};

      rst_n    = 1'b0;
      temp_sen = {4{8'd70}};
      lum_sen  = 8'd200;
      d_sen    = 1'b0;
      f_sen    = 1'b0;
      alrm_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {18'd0, b_alrm, f_alrm, heater, cooler, l_high, l_low, state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Climate hysteresis and lighting boundaries
      foreach (vecs[i]) begin
         temp_sen = {8'd70, 8'd70, 8'd70, vecs[i].t0};
         lum_sen  = vecs[i].lum;
         step();
         step();
         check($sformatf("heater_v%0d", i), {28'd0, heater}, {28'd0, vecs[i].heat});
         check($sformatf("cooler_v%0d", i), {28'd0, cooler}, {28'd0, vecs[i].cool});
         check($sformatf("l_high_v%0d", i), {31'd0, l_high}, {31'd0, vecs[i].lh});
         check($sformatf("l_low_v%0d", i), {31'd0, l_low}, {31'd0, vecs[i].ll});
         check($sformatf("state_v%0d", i), {30'd0, state}, 32'd0);
      end

      // Door pulse: early ack ignored, late ack releases; b_alrm high 6 cycles
      temp_sen = {4{8'd70}};
      lum_sen  = 8'd200;
      d_sen    = 1'b1;
      step();
      check("door_latency", {31'd0, b_alrm}, 32'd0);
      d_sen = 1'b0;
      len   = 0;
      for (int c = 1; c <= 10; c++) begin
         alrm_ack = (c == 2 || c == 6);
         step();
         if (b_alrm) len++;
         if (c == 6) check("door_state_c6", {30'd0, state}, 32'd1);
         if (c == 7) check("door_state_c7", {30'd0, state}, 32'd0);
      end
      alrm_ack = 1'b0;
      check("door_b_alrm_len", len, 32'd6);

      // Fire preempts door, then door_pend returns to DOOR
      temp_sen = {4{8'd60}};
      repeat (3) step();
      d_sen = 1'b1;
      step();
      step();
      check("pre_state_door", {30'd0, state}, 32'd1);
      check("pre_heater_door", {28'd0, heater}, 32'hf);
      step();
      f_sen = 1'b1;
      step();
      check("pre_b_alrm", {31'd0, b_alrm}, 32'd1);
      step();
      check("fire_state", {30'd0, state}, 32'd2);
      check("fire_b_alrm", {31'd0, b_alrm}, 32'd0);
      check("fire_f_alrm", {31'd0, f_alrm}, 32'd1);
      check("fire_heater", {28'd0, heater}, 32'd0);
      check("fire_lights", {30'd0, l_high, l_low}, 32'b10);
      d_sen    = 1'b0;
      f_sen    = 1'b0;
      alrm_ack = 1'b1;
      len      = 1;
      for (int i = 0; i < 20 && state == 2'd2; i++) begin
         step();
         if (f_alrm) len++;
      end
      check("fire_f_alrm_len", len, 32'd5);
      check("fire_exit_state", {30'd0, state}, 32'd1);
      check("fire_exit_b_alrm", {31'd0, b_alrm}, 32'd1);
      check("fire_exit_heater", {28'd0, heater}, 32'hf);
      len = 1;
      for (int i = 0; i < 20 && state == 2'd1; i++) begin
         step();
         if (b_alrm) len++;
      end
      check("pend_b_alrm_len", len, 32'd5);
      check("pend_exit_state", {30'd0, state}, 32'd0);
      alrm_ack = 1'b0;
      temp_sen = {4{8'd70}};
      repeat (3) step();

      // Simultaneous fire and door in RUN
      f_sen = 1'b1;
      d_sen = 1'b1;
      step();
      f_sen    = 1'b0;
      d_sen    = 1'b0;
      alrm_ack = 1'b1;
      step();
      check("sim_first_fire", {30'd0, state}, 32'd2);
      wait_state(2'd1, 10, "sim_then_door");
      check("sim_door_b_alrm", {31'd0, b_alrm}, 32'd1);
      wait_state(2'd0, 10, "sim_then_run");
      alrm_ack = 1'b0;
      repeat (2) step();

      // Asynchronous reset mid-FIRE
      f_sen = 1'b1;
      repeat (3) step();
      check("rst_pre_fire", {31'd0, f_alrm}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async_outputs",
            {18'd0, b_alrm, f_alrm, heater, cooler, l_high, l_low, state}, 32'd0);
      #2;
      f_sen = 1'b0;
      rst_n = 1'b1;
      step();
      check("rst_release_state", {30'd0, state}, 32'd0);
      check("rst_release_f_alrm", {31'd0, f_alrm}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
